// File: rtl/prio_enc_arbiter.sv
// ---------------------------------------------------------------------------
// prio_enc_arbiter
//
// Registered priority encoder / arbiter. Request lines are OR-ed into a
// pending set every cycle; one pending channel at a time is issued on a
// valid/ready output. Issue order is either fixed priority (highest index
// first) or round-robin starting after the last issued channel.
//
// Parameters
//   WIDTH   number of request lines (>= 2)
//   IDX_W   width of the issued index, $clog2(WIDTH)
//   CNT_W   width of the drop counter
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous, active-high reset
//   req_in      request lines, bit i = channel i
//   mode_rr     0 = fixed priority (highest index wins), 1 = round-robin
//   out_ready   consumer accepts out_idx this cycle
//   out_valid   out_idx / out_onehot carry an issued request
//   out_idx     issued channel index
//   out_onehot  one-hot of out_idx, all zero while !out_valid
//   pending     requests latched but not yet issued
//   drop_cnt    saturating count of cycles where a request hit an
//               already-pending channel
//
// Build option
//   PRIO_ENC_DROP_CNT_EN  when defined, drop_cnt is a live counter;
//                         otherwise drop_cnt is tied to zero.
// ---------------------------------------------------------------------------
module prio_enc_arbiter #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    input  logic             mode_rr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_onehot,
    output logic [WIDTH-1:0] pending,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [WIDTH-1:0] pending_q, pending_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0] sel_fp;
    logic [IDX_W-1:0] sel_rr;
    logic [IDX_W-1:0] sel;
    logic [WIDTH-1:0] sel_onehot;
    logic [WIDTH-1:0] pending_kept;
    logic             load;

    // Fixed priority: the last set bit found scanning upwards is the highest.
    always_comb begin
        sel_fp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) begin
                sel_fp = IDX_W'(i);
            end
        end
    end

    // Round-robin: scan rr_ptr+1 .. rr_ptr+WIDTH (mod WIDTH), take the first
    // hit. rr_ptr resets to WIDTH-1 so the first scan starts at bit 0.
    always_comb begin : rr_scan
        int  j;
        logic found;
        sel_rr = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 1; k <= WIDTH; k++) begin
            j = (int'(rr_ptr_q) + k) % WIDTH;
            if (!found && pending_q[j]) begin
                found  = 1'b1;
                sel_rr = IDX_W'(j);
            end
        end
    end

    always_comb begin
        sel          = mode_rr ? sel_rr : sel_fp;
        sel_onehot   = WIDTH'(1) << sel;
        load         = (!valid_q || out_ready) && (|pending_q);
        // The issued bit leaves pending at issue time; a same-cycle request
        // on that bit is OR-ed back in afterwards and re-pends it.
        pending_kept = load ? (pending_q & ~sel_onehot) : pending_q;
    end

    always_comb begin
        pending_d = pending_kept | req_in;
        valid_d   = valid_q;
        idx_d     = idx_q;
        rr_ptr_d  = rr_ptr_q;
        if (load) begin
            valid_d  = 1'b1;
            idx_d    = sel;
            rr_ptr_d = sel;
        end else if (valid_q && out_ready) begin
            // Accepted with nothing pending: no load possible, so go idle.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            rr_ptr_q  <= IDX_W'(WIDTH - 1);
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

`ifdef PRIO_ENC_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             collision;

    always_comb begin
        collision  = |(req_in & pending_kept);
        drop_cnt_d = drop_cnt_q;
        if (collision && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = valid_q ? (WIDTH'(1) << idx_q) : '0;
    assign pending    = pending_q;

endmodule

// File: tb/tb_prio_enc_arbiter.sv
module tb_prio_enc_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req_in;
    logic       mode_rr;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;
    logic [7:0] pending;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

`ifdef PRIO_ENC_DROP_CNT_EN
    localparam logic [7:0] DROP_EXP = 8'd2;
`else
    localparam logic [7:0] DROP_EXP = 8'd0;
`endif

    prio_enc_arbiter #(.WIDTH(8), .IDX_W(3), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .mode_rr    (mode_rr),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .pending    (pending),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks valid, index (only when valid), one-hot and pending together.
    task automatic chk_out(input string tag, input logic v, input logic [2:0] idx,
                           input logic [7:0] pend);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) chk({tag, ".idx"}, 32'(out_idx), 32'(idx));
        chk({tag, ".onehot"}, 32'(out_onehot), v ? 32'(8'd1 << idx) : 32'd0);
        chk({tag, ".pending"}, 32'(pending), 32'(pend));
    endtask

    initial begin
        rst = 1'b1; req_in = 8'h00; mode_rr = 1'b0; out_ready = 1'b1;

        // Reset state
        step(); step();
        rst = 1'b0;
        step();
        chk_out("reset", 1'b0, 3'd0, 8'h00);
        chk("reset.idx", 32'(out_idx), 32'd0);
        chk("reset.drop", 32'(drop_cnt), 32'd0);

        // Fixed priority 1010_0100 -> 7,5,2
        req_in = 8'hA4;
        step();
        req_in = 8'h00;
        chk_out("fp.latch", 1'b0, 3'd0, 8'hA4);
        step(); chk_out("fp.i7", 1'b1, 3'd7, 8'h24);
        step(); chk_out("fp.i5", 1'b1, 3'd5, 8'h04);
        step(); chk_out("fp.i2", 1'b1, 3'd2, 8'h00);
        step(); chk_out("fp.idle", 1'b0, 3'd0, 8'h00);

        // Round-robin from reset: 0..7, then re-request 3 and 0 -> 0, 3
        rst = 1'b1;
        step();
        rst = 1'b0;
        mode_rr = 1'b1;
        req_in = 8'hFF;
        step();
        req_in = 8'h00;
        chk_out("rr.latch", 1'b0, 3'd0, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) req_in = 8'h09;
            step();
            req_in = 8'h00;
            chk_out($sformatf("rr.seq%0d", i), 1'b1, 3'(i),
                    (i == 7) ? 8'h09 : 8'(8'hFF << (i + 1)));
        end
        step(); chk_out("rr.wrap0", 1'b1, 3'd0, 8'h08);
        step(); chk_out("rr.wrap3", 1'b1, 3'd3, 8'h00);
        step(); chk_out("rr.idle", 1'b0, 3'd0, 8'h00);

        // Backpressure: idx 6 held while bit 1 accumulates
        mode_rr = 1'b0;
        out_ready = 1'b0;
        req_in = 8'h40;
        step();
        req_in = 8'h00;
        step(); chk_out("bp.issue6", 1'b1, 3'd6, 8'h00);
        req_in = 8'h02;
        step();
        req_in = 8'h00;
        chk_out("bp.hold1", 1'b1, 3'd6, 8'h02);
        for (int i = 2; i <= 5; i++) begin
            step();
            chk_out($sformatf("bp.hold%0d", i), 1'b1, 3'd6, 8'h02);
        end
        out_ready = 1'b1;
        step(); chk_out("bp.next1", 1'b1, 3'd1, 8'h00);
        step(); chk_out("bp.idle", 1'b0, 3'd0, 8'h00);

        // Collision: 8'h10 held 4 cycles with out_ready=0
        out_ready = 1'b0;
        req_in = 8'h10;
        step(); chk_out("drop.c1", 1'b0, 3'd0, 8'h10);
        chk("drop.c1.cnt", 32'(drop_cnt), 32'd0);
        step(); chk_out("drop.c2", 1'b1, 3'd4, 8'h10);
        chk("drop.c2.cnt", 32'(drop_cnt), 32'd0);
        step();
        step();
        req_in = 8'h00;
        chk("drop.c4.cnt", 32'(drop_cnt), 32'(DROP_EXP));
        step(); chk_out("drop.hold", 1'b1, 3'd4, 8'h10);
        chk("drop.hold.cnt", 32'(drop_cnt), 32'(DROP_EXP));
        out_ready = 1'b1;
        step(); chk_out("drop.reissue", 1'b1, 3'd4, 8'h00);
        step(); chk_out("drop.idle", 1'b0, 3'd0, 8'h00);

        // Reset mid-transfer
        out_ready = 1'b0;
        req_in = 8'h1F;
        step();
        req_in = 8'h00;
        step(); chk_out("mid.pre", 1'b1, 3'd4, 8'h0F);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("mid.rst", 1'b0, 3'd0, 8'h00);
        chk("mid.rst.idx", 32'(out_idx), 32'd0);
        chk("mid.rst.drop", 32'(drop_cnt), 32'd0);

        // Round-robin pointer restored by reset: scan starts at bit 0
        mode_rr = 1'b1;
        out_ready = 1'b1;
        req_in = 8'h81;
        step();
        req_in = 8'h00;
        step(); chk_out("rr2.first", 1'b1, 3'd0, 8'h80);
        // Mode switch to fixed affects the next load only
        mode_rr = 1'b0;
        req_in = 8'h02;
        step();
        req_in = 8'h00;
        chk_out("mode.sw", 1'b1, 3'd7, 8'h02);
        step(); chk_out("mode.sw2", 1'b1, 3'd1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
